// File: rtl/apb_arbiter.sv
// Round-robin APB arbiter: N requester ports share one completer, one owner per transfer.
// Winner's request is captured in IDLE and replayed to the completer through SETUP/ACCESS.
module apb_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                          pclk_i,
  input  logic                          presetn_i,
  input  logic [N_MASTERS-1:0]          m_psel_i,
  input  logic [N_MASTERS-1:0]          m_penable_i,
  input  logic [N_MASTERS-1:0]          m_pwrite_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_paddr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_pwdata_i,
  output logic [DATA_W-1:0]             m_prdata_o,
  output logic [N_MASTERS-1:0]          m_pready_o,
  output logic [N_MASTERS-1:0]          m_pslverr_o,
  output logic                          s_psel_o,
  output logic                          s_penable_o,
  output logic                          s_pwrite_o,
  output logic [ADDR_W-1:0]             s_paddr_o,
  output logic [DATA_W-1:0]             s_pwdata_o,
  input  logic [DATA_W-1:0]             s_prdata_i,
  input  logic                          s_pready_i,
  input  logic                          s_pslverr_i,
  output logic [N_MASTERS-1:0]          grant_o
);

  localparam int unsigned IdxW = $clog2(N_MASTERS);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q, state_d;
  logic [N_MASTERS-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;

  logic                  any_req;
  logic [IdxW-1:0]       win_idx;
  int unsigned           cand;
  logic                  done;
  logic                  unused_penable;

  assign unused_penable = ^m_penable_i;

  // Walk from farthest to nearest so the candidate closest to last_q+1 is written last.
  always_comb begin
    win_idx = last_q;
    any_req = 1'b0;
    cand    = 0;
    for (int unsigned k = N_MASTERS; k >= 1; k--) begin
      cand = (32'(last_q) + k) % N_MASTERS;
      if (m_psel_i[IdxW'(cand)]) begin
        win_idx = IdxW'(cand);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d  = StSetup;
          grant_d  = {{(N_MASTERS-1){1'b0}}, 1'b1} << win_idx;
          last_d   = win_idx;
          paddr_d  = m_paddr_i[32'(win_idx)*ADDR_W +: ADDR_W];
          pwdata_d = m_pwdata_i[32'(win_idx)*DATA_W +: DATA_W];
          pwrite_d = m_pwrite_i[win_idx];
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (s_pready_i) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (!presetn_i) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      last_q   <= IdxW'(N_MASTERS - 1);
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
    end
  end

  // Gated by presetn_i so a transfer being reset never leaks a pready.
  assign done = presetn_i && (state_q == StAccess) && s_pready_i;

  assign s_psel_o    = (state_q != StIdle);
  assign s_penable_o = (state_q == StAccess);
  assign s_pwrite_o  = pwrite_q;
  assign s_paddr_o   = paddr_q;
  assign s_pwdata_o  = pwdata_q;
  assign grant_o     = grant_q;
  assign m_prdata_o  = s_prdata_i;
  assign m_pready_o  = done ? grant_q : '0;
  assign m_pslverr_o = (done && s_pslverr_i) ? grant_q : '0;

endmodule
